// File: rtl/if_stage_bp_pkg.sv
// Shared constants and 2-bit saturating branch-counter helpers for the
// instruction-fetch stage and its branch target buffer.
package if_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic ctr_e ctr_inc(input ctr_e c);
        return (c == ST) ? ST : ctr_e'(c + 2'd1);
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/if_stage_bp_btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// registered training from EX. A same-index update is seen by the next lookup.
module btb_dm
    import if_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            hit_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [BTB_ENTRIES];
    ctr_e             ctr_q    [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]  target_q [BTB_ENTRIES];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [3:0]       unused_low_bits;

    assign l_idx = lookup_pc_i[IDX_W+1:2];
    assign l_tag = lookup_pc_i[XLEN-1:IDX_W+2];
    assign u_idx = upd_pc_i[IDX_W+1:2];
    assign u_tag = upd_pc_i[XLEN-1:IDX_W+2];
    assign unused_low_bits = {lookup_pc_i[1:0], upd_pc_i[1:0]};

    assign hit_o        = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign pred_taken_o = hit_o && ctr_q[l_idx][1];
    assign target_o     = target_q[l_idx];
    assign u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else if (upd_valid_i) begin
            if (upd_taken_i) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= u_hit ? ctr_inc(ctr_q[u_idx]) : WT;
            end else if (u_hit) begin
                ctr_q[u_idx] <= ctr_dec(ctr_q[u_idx]);
            end
        end
    end

    // Tag/target need no reset: they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (upd_valid_i && upd_taken_i) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target_i;
        end
    end

endmodule

// File: rtl/if_stage_bp.sv
// RV32I instruction-fetch stage: PC register, next-PC selection with BTB
// prediction, and the IF/ID pipeline register carrying prediction metadata.
module if_stage_bp
    import if_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            flushD,
    input  logic            redirectE,
    input  logic [XLEN-1:0] redirect_pcE,
    input  logic            upd_validE,
    input  logic [XLEN-1:0] upd_pcE,
    input  logic            upd_takenE,
    input  logic [XLEN-1:0] upd_targetE,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD,
    output logic            predTakenD,
    output logic [XLEN-1:0] predTargetD
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            btb_hit;
    logic            pred_taken_f;
    logic [XLEN-1:0] btb_target;
    logic [XLEN-1:0] pred_target_f;

    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;
    logic            valid_q, valid_d;
    logic            ptaken_q, ptaken_d;
    logic [XLEN-1:0] ptarget_q, ptarget_d;

    btb_dm #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc_i  (pc_q),
        .hit_o        (btb_hit),
        .pred_taken_o (pred_taken_f),
        .target_o     (btb_target),
        .upd_valid_i  (upd_validE),
        .upd_pc_i     (upd_pcE),
        .upd_taken_i  (upd_takenE),
        .upd_target_i (upd_targetE)
    );

    assign pc_plus4      = pc_q + XLEN'(4);
    assign pred_target_f = btb_hit ? btb_target : pc_plus4;
    assign imem_addr     = pc_q;

    // A redirect from EX wins over a stall: the wrong-path fetch must go.
    always_comb begin
        pc_d = pc_plus4;
        if (redirectE) begin
            pc_d = redirect_pcE & ALIGN_MASK;
        end else if (stallF) begin
            pc_d = pc_q;
        end else if (pred_taken_f) begin
            pc_d = pred_target_f & ALIGN_MASK;
        end
    end

    always_comb begin
        inst_d    = inst_q;
        pcd_d     = pcd_q;
        pcp4_d    = pcp4_q;
        valid_d   = valid_q;
        ptaken_d  = ptaken_q;
        ptarget_d = ptarget_q;
        if (redirectE || flushD) begin
            inst_d    = NOP_INST;
            valid_d   = 1'b0;
            ptaken_d  = 1'b0;
            ptarget_d = '0;
        end else if (!stallF) begin
            inst_d    = imem_rdata;
            pcd_d     = pc_q;
            pcp4_d    = pc_plus4;
            valid_d   = 1'b1;
            ptaken_d  = pred_taken_f;
            ptarget_d = pred_target_f;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            pcd_q     <= '0;
            pcp4_q    <= '0;
            valid_q   <= 1'b0;
            ptaken_q  <= 1'b0;
            ptarget_q <= '0;
        end else begin
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            pcd_q     <= pcd_d;
            pcp4_q    <= pcp4_d;
            valid_q   <= valid_d;
            ptaken_q  <= ptaken_d;
            ptarget_q <= ptarget_d;
        end
    end

    assign instD       = inst_q;
    assign PCD         = pcd_q;
    assign PCPlus4D    = pcp4_q;
    assign validD      = valid_q;
    assign predTakenD  = ptaken_q;
    assign predTargetD = ptarget_q;

endmodule

// File: tb/tb_if_stage_bp.sv
// Fetch-stage bench: directed scenarios pinned with literal expectations, then
// randomized traffic checked every cycle against a behavioural fetch/BTB model.
module tb_if_stage_bp;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallF = 1'b0, flushD = 1'b0, redirectE = 1'b0;
    logic [31:0] redirect_pcE = '0;
    logic        upd_validE = 1'b0, upd_takenE = 1'b0;
    logic [31:0] upd_pcE = '0, upd_targetE = '0;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instD, PCD, PCPlus4D, predTargetD;
    logic        validD, predTakenD;

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    // behavioural model state
    bit [31:0] m_pc, m_inst, m_pcd, m_pcp4, m_ptgt;
    bit        m_v, m_pt, m_pcd_known;
    bit        m_bv   [16];
    bit [31:0] m_btag [16];
    bit [31:0] m_btgt [16];
    int        m_ctr  [16];

    if_stage_bp #(
        .XLEN        (32),
        .RESET_PC    (32'h0000_0000),
        .BTB_ENTRIES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallF       (stallF),
        .flushD       (flushD),
        .redirectE    (redirectE),
        .redirect_pcE (redirect_pcE),
        .upd_validE   (upd_validE),
        .upd_pcE      (upd_pcE),
        .upd_takenE   (upd_takenE),
        .upd_targetE  (upd_targetE),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instD        (instD),
        .PCD          (PCD),
        .PCPlus4D     (PCPlus4D),
        .validD       (validD),
        .predTakenD   (predTakenD),
        .predTargetD  (predTargetD)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] mem_word(input bit [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_inst = NOP; m_pcd = 0; m_pcp4 = 0; m_ptgt = 0;
        m_v = 0; m_pt = 0; m_pcd_known = 1;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = 0; m_ctr[i] = 1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pcf", imem_addr, m_pc);
            chk("validD", {31'b0, validD}, {31'b0, m_v});
            chk("instD", instD, m_inst);
            chk("predTakenD", {31'b0, predTakenD}, {31'b0, m_pt});
            chk("predTargetD", predTargetD, m_ptgt);
            if (m_pcd_known) begin
                chk("PCD", PCD, m_pcd);
                chk("PCPlus4D", PCPlus4D, m_pcp4);
            end
        end
    end

    // One clock: drive inputs, evaluate the model's next state, commit it at the edge.
    task automatic step(input bit st, input bit fl, input bit rd, input bit [31:0] rpc,
                        input bit uv, input bit [31:0] upc, input bit ut, input bit [31:0] utgt);
        int        li, ui;
        bit        hit, pt, uhit;
        bit [31:0] ptgt, npc;
        bit [31:0] n_inst, n_pcd, n_pcp4, n_ptgt;
        bit        n_v, n_pt, n_known;
        stallF = st; flushD = fl; redirectE = rd; redirect_pcE = rpc;
        upd_validE = uv; upd_pcE = upc; upd_takenE = ut; upd_targetE = utgt;

        li   = int'((m_pc >> 2) % 16);
        hit  = m_bv[li] && (m_btag[li] == (m_pc >> 6));
        pt   = hit && (m_ctr[li] >= 2);
        ptgt = hit ? m_btgt[li] : m_pc + 32'd4;
        if (rd)      npc = rpc & ~32'd3;
        else if (st) npc = m_pc;
        else if (pt) npc = ptgt & ~32'd3;
        else         npc = m_pc + 32'd4;

        n_inst = m_inst; n_pcd = m_pcd; n_pcp4 = m_pcp4; n_ptgt = m_ptgt;
        n_v = m_v; n_pt = m_pt; n_known = m_pcd_known;
        if (rd || fl) begin
            n_inst = NOP; n_v = 0; n_pt = 0; n_ptgt = 0; n_known = 0;
        end else if (!st) begin
            n_inst = mem_word(m_pc); n_pcd = m_pc; n_pcp4 = m_pc + 32'd4;
            n_v = 1; n_pt = pt; n_ptgt = ptgt; n_known = 1;
        end

        @(posedge clk);
        if (uv) begin
            ui   = int'((upc >> 2) % 16);
            uhit = m_bv[ui] && (m_btag[ui] == (upc >> 6));
            if (ut && uhit) begin
                m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
                m_btgt[ui] = utgt;
            end else if (ut) begin
                m_bv[ui] = 1; m_btag[ui] = upc >> 6; m_btgt[ui] = utgt; m_ctr[ui] = 2;
            end else if (uhit) begin
                m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
            end
        end
        m_pc = npc; m_inst = n_inst; m_pcd = n_pcd; m_pcp4 = n_pcp4;
        m_ptgt = n_ptgt; m_v = n_v; m_pt = n_pt; m_pcd_known = n_known;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect(input bit [31:0] a);
        step(0, 0, 1, a, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle while a stall and redirect are pending.
    task automatic mid_reset();
        stallF = 1; redirectE = 1; redirect_pcE = 32'h0000_0300;
        #1;
        rst = 0;
        model_reset();
        #1;
        chk("async_rst_pcf", imem_addr, 32'h0);
        chk("async_rst_validD", {31'b0, validD}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        #1;
        rst = 1;

        // 1: straight-line fetch
        chk("lit_reset_pcf", imem_addr, 32'h0);
        chk("lit_reset_instD", instD, NOP);
        idle(); chk("lit_pcf_4", imem_addr, 32'h4);
        chk("lit_validD_c2", {31'b0, validD}, 32'h1);
        idle(); chk("lit_pcf_8", imem_addr, 32'h8);
        idle(); chk("lit_pcf_c", imem_addr, 32'hC);
        idle();
        // 2: stall
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0);
            chk("lit_stall_pcf", imem_addr, 32'h10);
            chk("lit_stall_pcd", PCD, 32'hC);
        end
        idle(); chk("lit_release_pcf", imem_addr, 32'h14);
        // 3: train 0x20 -> 0x80
        step(0, 0, 0, 0, 1, 32'h20, 1, 32'h80);
        idle(); idle();
        chk("lit_at_20", imem_addr, 32'h20);
        idle();
        chk("lit_pred_pcf", imem_addr, 32'h80);
        chk("lit_pred_takenD", {31'b0, predTakenD}, 32'h1);
        chk("lit_pred_targetD", predTargetD, 32'h80);
        // 4: two not-taken updates
        step(0, 0, 0, 0, 1, 32'h20, 0, 0);
        step(0, 0, 0, 0, 1, 32'h20, 0, 0);
        redirect(32'h20);
        idle();
        chk("lit_nt_pcf", imem_addr, 32'h24);
        chk("lit_nt_takenD", {31'b0, predTakenD}, 32'h0);
        // 5: redirect beats stall
        step(1, 0, 1, 32'h200, 0, 0, 0, 0);
        chk("lit_redir_pcf", imem_addr, 32'h200);
        chk("lit_redir_validD", {31'b0, validD}, 32'h0);
        chk("lit_redir_instD", instD, NOP);
        // PC+4 wraps
        redirect(32'hFFFF_FFFC);
        idle();
        chk("lit_wrap_pcf", imem_addr, 32'h0);
        chk("lit_wrap_pcp4", PCPlus4D, 32'h0);
        // 6: aliasing and reset clearing the BTB
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 32'h20, 1, 32'h80);
        redirect(32'h420);
        idle();
        chk("lit_alias_pcf", imem_addr, 32'h424);
        chk("lit_alias_takenD", {31'b0, predTakenD}, 32'h0);
        redirect(32'h20);
        idle();
        chk("lit_pre_rst_pcf", imem_addr, 32'h80);
        mid_reset();
        redirect(32'h20);
        idle();
        chk("lit_post_rst_pcf", imem_addr, 32'h24);
        chk("lit_post_rst_takenD", {31'b0, predTakenD}, 32'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit [31:0] rpc, upc, utgt;
            rpc  = ($urandom_range(0, 63) * 4) | ($urandom_range(0, 3) == 0 ? 32'h400 : 32'h0)
                   | 32'($urandom_range(0, 3));
            upc  = ($urandom_range(0, 63) * 4) | ($urandom_range(0, 5) == 0 ? 32'h400 : 32'h0);
            utgt = $urandom_range(0, 63) * 4;
            if ($urandom_range(0, 199) == 0) mid_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 rpc, $urandom_range(0, 9) < 4, upc, $urandom_range(0, 2) != 0, utgt);
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
